// File: rtl/sll_alu_arbiter_pkg.sv
// Shared types and constants for the sll_ALU arbiter: FSM state encoding,
// default datapath width and settle-count normalisation.
package sll_alu_arbiter_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // A settle time of zero would skip the ISSUE hold entirely; clamp to one cycle.
    function automatic int settle_eff(input int settle_cyc);
        return (settle_cyc < 1) ? 1 : settle_cyc;
    endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Combinational two-way round-robin grant: a lone requester always wins,
// contention is resolved in favour of the requester named by ptr_i.
module alu_rr_arb2 (
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (valid0_i && (!valid1_i || !ptr_i)) begin
            gnt_o[0] = 1'b1;
        end else if (valid1_i) begin
            gnt_o[1] = 1'b1;
        end
    end

endmodule

// File: rtl/sll_ALU.sv
// Combinational shift-left-logical ALU: s = a << b[log2(W)-1:0], with carry
// (last bit shifted out), overflow (any set bit shifted out) and a==b flag.
module sll_ALU #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] s,
    output logic              of,
    output logic              cary,
    output logic              eq
);

    localparam int SH_W = $clog2(DATA_W);

    logic [2*DATA_W-1:0] wide;

    // Shifting into a double-width word keeps every bit that falls off the top.
    assign wide = {{DATA_W{1'b0}}, a} << b[SH_W-1:0];
    assign s    = wide[DATA_W-1:0];
    assign cary = wide[DATA_W];
    assign of   = |wide[2*DATA_W-1:DATA_W];
    assign eq   = (a == b);

endmodule

// File: rtl/sll_alu_arbiter.sv
// Shares one sll_ALU between two requesters: round-robin accept, operand
// capture, programmable settle hold, and a registered tagged response.
module sll_alu_arbiter
    import sll_alu_arbiter_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_s,
    output logic              rsp_of,
    output logic              rsp_cary,
    output logic              rsp_eq,
    output logic              busy
);

    localparam int               SETTLE_EFF = settle_eff(SETTLE_CYC);
    localparam int               CNT_W      = $clog2(SETTLE_EFF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SETTLE_EFF - 1);

    state_t              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic                op_id_q, op_id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_s_q, rsp_s_d;
    logic                rsp_of_q, rsp_of_d;
    logic                rsp_cary_q, rsp_cary_d;
    logic                rsp_eq_q, rsp_eq_d;

    logic [1:0]          gnt;
    logic [DATA_W-1:0]   alu_s;
    logic                alu_of;
    logic                alu_cary;
    logic                alu_eq;

    alu_rr_arb2 u_arb (
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (gnt)
    );

    // The ALU only ever sees the captured operands, so requesters may change
    // their buses freely once accepted.
    sll_ALU #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a    (op_a_q),
        .b    (op_b_q),
        .s    (alu_s),
        .of   (alu_of),
        .cary (alu_cary),
        .eq   (alu_eq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 1'b0;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_s_q     <= '0;
            rsp_of_q    <= 1'b0;
            rsp_cary_q  <= 1'b0;
            rsp_eq_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_s_q     <= rsp_s_d;
            rsp_of_q    <= rsp_of_d;
            rsp_cary_q  <= rsp_cary_d;
            rsp_eq_q    <= rsp_eq_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_s_d     = rsp_s_q;
        rsp_of_d    = rsp_of_q;
        rsp_cary_d  = rsp_cary_q;
        rsp_eq_d    = rsp_eq_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req0_ready = gnt[0];
                req1_ready = gnt[1];
                if (gnt[0]) begin
                    op_a_d  = req0_a;
                    op_b_d  = req0_b;
                    op_id_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end else if (gnt[1]) begin
                    op_a_d  = req1_a;
                    op_b_d  = req1_b;
                    op_id_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cnt_q == CNT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = op_id_q;
                    rsp_s_d     = alu_s;
                    rsp_of_d    = alu_of;
                    rsp_cary_d  = alu_cary;
                    rsp_eq_d    = alu_eq;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                // Fairness pointer moves only on completion, to the other requester.
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = ~rsp_id_q;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_of    = rsp_of_q;
    assign rsp_cary  = rsp_cary_q;
    assign rsp_eq    = rsp_eq_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
